async_fanout_buffer: RTL and testbench
======================================

Name: async_fanout_buffer

Overview:
- Elastic multi-entry buffer node for the req/ack dataflow fabric.
- Replaces chains of single-entry "reg" balancing nodes with one parametrised FIFO of configurable depth.
- Serves output_size consumers, each with its own read pointer, so a slow consumer no longer stalls its siblings until the buffer fills.
- Sits between a producing operator (its upstream pull port) and N consuming operators (its downstream ports).

Parameters:
- data_width, 32, token width in bits
- depth, 4, entries; power of two, >= 2
- output_size, 3, number of independent consumer ports, >= 1
- initial_value, 0, preload token value; used only when ASYNC_BUF_PRELOAD_EN is defined

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req_l  output  1  pull request to upstream; registered
- ack_l  input  1  upstream ack pulse; din valid while high
- din  input  data_width  upstream token
- req_r  input  output_size  per-consumer pull request, level
- ack_r  output  output_size  per-consumer one-cycle ack pulse; registered
- dout  output  data_width*output_size  per-consumer token; slice k = [data_width*(k+1)-1:data_width*k]; held between acks
- count  output  clog2(depth+1)  occupancy, equal to max over k of lvl[k]

Behaviour:
- Reset (rst low, asynchronous, no clock needed):
  - req_l=0, ack_r=0, dout=0, count=0.
  - wr_ptr and all rd_ptr[k] = 0; buffer contents discarded.
  - Reset asserted mid-operation drops every in-flight token.
- Pointers are clog2(depth)+1 bits; the MSB is the wrap bit.
  - lvl[k] = wr_ptr - rd_ptr[k], modulo 2^(AW+1).
  - free = depth - max_k lvl[k].
- Upstream write side:
  - At an edge with ack_l=1 and req_l=1: mem[wr_ptr[AW-1:0]] <= din, wr_ptr++.
  - req_l next = (free after this cycle's write and reads) != 0.
  - ack_l while req_l=0 is ignored; no write occurs.
- Downstream side, per consumer k:
  - At an edge with req_r[k]=1, ack_r[k]=0 and lvl[k]!=0: ack_r[k]<=1, dout[k]<=mem[rd_ptr[k]], rd_ptr[k]++.
  - Otherwise ack_r[k]<=0.
  - Max rate is one token per 2 cycles per consumer.
- An entry is freed only after every consumer has read it.
- No bypass:
  - A token written at edge N is first acked at edge N+1.
  - Write into an empty buffer and read in the same cycle: the read is not granted.
- A read and a write to different slots in the same cycle both proceed; free accounts for both.
- Full (free=0): req_l=0; one read by the slowest consumer raises req_l at the next edge.
- Consumers are independent; a consumer k with lvl[k]=0 never pulses ack_r[k].
- Tokens are delivered in order, with no duplication and no loss, to each consumer.

Optional Feature:
- Macro ASYNC_BUF_PRELOAD_EN.
- Defined:
  - Reset leaves one token, mem[0]=initial_value, with wr_ptr=1 and count=1.
  - Every consumer receives initial_value first.
  - Used for loop-carried dependencies.
- Undefined:
  - Buffer resets empty and initial_value is unused.

Decomposition:
- Shared package async_pkg:
  - clog2 function
  - pointer-width localparam helper
  - dataflow op-name string constants, shared with async_operator
- Sub-module async_buf_rd_port, generated output_size times. Each instance contains:
  - its rd_ptr
  - the lvl computation
  - the ack_r/dout register
  - its lvl output to the top for the free/count max reduction
- The top level holds mem, wr_ptr, req_l and the reduction logic.

Test Plan:
- Reset: drive rst low between edges → all outputs 0 immediately. After release, req_l=1 at the first edge.
- Fill, depth=4, output_size=1, req_r=0: producer acks 0,1,2,3 → count=4, req_l=0; a 5th ack is dropped. Raise req_r → consumer receives 0,1,2,3 on ack pulses every other cycle.
- Skew, output_size=3: req_r[0]=1 with req_r[2:1]=0, after 4 writes → consumer 0 gets 0..3, count stays 4 and req_l stays 0. Releasing consumer 1 alone keeps req_l=0; releasing consumer 2 as well drains the buffer and req_l rises.
- Latency: empty buffer, req_r=all 1, write value 7 at edge N → ack_r=all 1 with dout slices=7 at edge N+1, not earlier.
- Stress: depth=2, 5000 tokens, each consumer stalling randomly 30% of cycles → each consumer sees 0..4999 in order. Producer/consumer counts match.
- Preload: with ASYNC_BUF_PRELOAD_EN and initial_value=9 → after reset count=1, and the first token seen by every consumer is 9, then 0,1,...

Source files
------------

// File: rtl/async_pkg.sv
// Shared helpers for the req/ack dataflow fabric: width math and operator names.
package async_pkg;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Pointer width for a power-of-two FIFO: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Operator names shared with async_operator for netlist annotation.
    localparam string OP_NAME_BUFFER   = "buffer";
    localparam string OP_NAME_OPERATOR = "operator";
    localparam string OP_NAME_FANOUT   = "fanout";

endpackage

// File: rtl/async_fanout_buffer_if.sv
// Handshake bundle of async_fanout_buffer: one upstream pull port, output_size
// downstream ports and the occupancy count.
// master = environment (producer + consumers), slave = the buffer itself.
interface async_fanout_buffer_if
    import async_pkg::*;
#(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int output_size = 3
);
    localparam int CW = clog2(depth + 1);

    logic                              req_l;
    logic                              ack_l;
    logic [data_width-1:0]             din;
    logic [output_size-1:0]            req_r;
    logic [output_size-1:0]            ack_r;
    logic [data_width*output_size-1:0] dout;
    logic [CW-1:0]                     count;

    modport master (
        input  req_l, ack_r, dout, count,
        output ack_l, din, req_r
    );

    modport slave (
        output req_l, ack_r, dout, count,
        input  ack_l, din, req_r
    );

endinterface

// File: rtl/async_buf_rd_port.sv
// One consumer port of the fanout buffer: private read pointer, level against
// the shared write pointer, and the registered ack/dout pair.
module async_buf_rd_port
    import async_pkg::*;
#(
    parameter  int data_width = 32,
    parameter  int depth      = 4,
    localparam int AW         = clog2(depth),
    localparam int PW         = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_r,
    input  logic [PW-1:0]         wr_ptr,
    input  logic [data_width-1:0] rd_data,
    output logic [AW-1:0]         rd_addr,
    output logic [PW-1:0]         rd_ptr_nxt,
    output logic [PW-1:0]         lvl,
    output logic                  ack_r,
    output logic [data_width-1:0] dout
);

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  ack_r_q, ack_r_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic                  grant;

    // Grant a read when asked, not in the ack cycle, and a token is pending.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        lvl      = wr_ptr - rd_ptr_q;
        grant    = req_r && !ack_r_q && (lvl != '0);
        rd_ptr_d = rd_ptr_q;
        ack_r_d  = 1'b0;
        dout_d   = dout_q;
        if (grant) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            ack_r_d  = 1'b1;
            dout_d   = rd_data;
        end
    end

    // Port state; dout holds its token between acks.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            rd_ptr_q <= '0;
            ack_r_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            ack_r_q  <= ack_r_d;
            dout_q   <= dout_d;
        end
    end

    assign rd_addr    = rd_ptr_q[AW-1:0];
    assign rd_ptr_nxt = rd_ptr_d;
    assign ack_r      = ack_r_q;
    assign dout       = dout_q;

endmodule

// File: rtl/async_fanout_buffer.sv
// Elastic multi-entry buffer node with output_size independent consumers.
// Shared storage and write pointer live here; each consumer owns a read port.
// An entry is freed only after the slowest consumer has read it.
// Optional: define ASYNC_BUF_PRELOAD_EN to leave one initial_value token
// in the buffer after reset (loop-carried dependencies).
module async_fanout_buffer
    import async_pkg::*;
#(
    parameter int                    data_width    = 32,
    parameter int                    depth         = 4,
    parameter int                    output_size   = 3,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input logic                  clk,
    input logic                  rst,
    async_fanout_buffer_if.slave bus
);

    localparam int AW = clog2(depth);
    localparam int PW = ptr_width(depth);
    localparam int CW = clog2(depth + 1);

`ifdef ASYNC_BUF_PRELOAD_EN
    localparam logic [PW-1:0] WR_PTR_RST = PW'(1);
`else
    localparam logic [PW-1:0] WR_PTR_RST = '0;
`endif

    logic [data_width-1:0]             mem_q [depth];
    logic [PW-1:0]                     wr_ptr_q, wr_ptr_d;
    logic                              req_l_q, req_l_d;
    logic                              wr_en;
    logic [PW-1:0]                     max_lvl, max_lvl_nxt, lvl_nxt;
    logic                              pre_valid_q;

    logic [AW-1:0]                     rd_addr    [output_size];
    logic [data_width-1:0]             rd_data    [output_size];
    logic [PW-1:0]                     rd_ptr_nxt [output_size];
    logic [PW-1:0]                     lvl        [output_size];
    logic [data_width-1:0]             dout_arr   [output_size];
    logic [output_size-1:0]            ack_r_vec;
    logic [data_width*output_size-1:0] dout_flat;

    // Write acceptance, next write pointer, and the slowest-consumer reductions.
    always_comb begin
        wr_en       = bus.ack_l && req_l_q;
        wr_ptr_d    = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        max_lvl     = '0;
        max_lvl_nxt = '0;
        lvl_nxt     = '0;
        for (int k = 0; k < output_size; k++) begin
            if (lvl[k] > max_lvl) max_lvl = lvl[k];
            lvl_nxt = wr_ptr_d - rd_ptr_nxt[k];
            if (lvl_nxt > max_lvl_nxt) max_lvl_nxt = lvl_nxt;
        end
        // Keep pulling while at least one slot will be free after this edge.
        req_l_d = (max_lvl_nxt != PW'(depth));
    end

    // Write pointer and registered upstream request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= WR_PTR_RST;
            req_l_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            req_l_q  <= req_l_d;
        end
    end

    // Token storage written on an accepted upstream ack.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers alone define which entries are live.
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.din;
    end

`ifdef ASYNC_BUF_PRELOAD_EN
    logic pre_valid_d;

    // Slot 0 reads as initial_value until the producer first overwrites it.
    always_comb begin
        pre_valid_d = pre_valid_q && !(wr_en && (wr_ptr_q[AW-1:0] == '0));
    end

    // Preload marker, set by reset in place of resetting the storage array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre_valid_q <= 1'b1;
        else      pre_valid_q <= pre_valid_d;
    end
`else
    assign pre_valid_q = 1'b0;
`endif

    // Per-consumer read data, with the preload token substituted for slot 0.
    always_comb begin
        for (int k = 0; k < output_size; k++) begin
            rd_data[k] = (pre_valid_q && (rd_addr[k] == '0)) ? initial_value
                                                              : mem_q[rd_addr[k]];
        end
    end

    for (genvar k = 0; k < output_size; k++) begin : g_rd
        async_buf_rd_port #(
            .data_width (data_width),
            .depth      (depth)
        ) u_port (
            .clk        (clk),
            .rst        (rst),
            .req_r      (bus.req_r[k]),
            .wr_ptr     (wr_ptr_q),
            .rd_data    (rd_data[k]),
            .rd_addr    (rd_addr[k]),
            .rd_ptr_nxt (rd_ptr_nxt[k]),
            .lvl        (lvl[k]),
            .ack_r      (ack_r_vec[k]),
            .dout       (dout_arr[k])
        );
    end

    // Pack the per-consumer tokens into the flat dout bus.
    always_comb begin
        dout_flat = '0;
        for (int k = 0; k < output_size; k++) begin
            dout_flat[k*data_width +: data_width] = dout_arr[k];
        end
    end

    assign bus.req_l = req_l_q;
    assign bus.ack_r = ack_r_vec;
    assign bus.dout  = dout_flat;
    assign bus.count = CW'(max_lvl);

endmodule

// File: tb/tb_async_fanout_buffer.sv
// Scoreboard bench for async_fanout_buffer (depth 4, three consumers).
// The stimulus thread pushes each accepted token into every consumer's queue;
// a negedge monitor pops and compares whenever a consumer sees an ack.
module tb_async_fanout_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NOUT  = 3;
    localparam int INIT  = 9;
`ifdef ASYNC_BUF_PRELOAD_EN
    localparam int PRE   = 1;
`else
    localparam int PRE   = 0;
`endif
    localparam int N_STRESS = 2000;

    logic clk;
    logic rst;

    async_fanout_buffer_if #(.data_width(DW), .depth(DEPTH), .output_size(NOUT)) bus ();

    async_fanout_buffer #(
        .data_width    (DW),
        .depth         (DEPTH),
        .output_size   (NOUT),
        .initial_value (DW'(INIT))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp;
    int          n_err;
    int unsigned exp_q [NOUT][$];
    int          n_rcv [NOUT];
    int          n_sent;
    logic [NOUT-1:0] prev_ack;
    logic        stress_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every consumer ack must match the head of that consumer's queue.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < NOUT; k++) begin
                if (bus.ack_r[k]) begin
                    check($sformatf("ack_gap[%0d]", k), 64'(prev_ack[k]), 64'd0);
                    if (exp_q[k].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_ack[%0d]: got %0h, expected no token", k,
                                 bus.dout[k*DW +: DW]);
                    end else begin
                        check($sformatf("dout[%0d]", k), 64'(bus.dout[k*DW +: DW]),
                              64'(exp_q[k].pop_front()));
                        n_rcv[k]++;
                    end
                end
            end
            prev_ack = bus.ack_r;
        end else begin
            prev_ack = '0;
        end
    end

    task automatic push_all(input int unsigned v);
        for (int k = 0; k < NOUT; k++) exp_q[k].push_back(v);
    endtask

    task automatic clear_expect();
        for (int k = 0; k < NOUT; k++) exp_q[k].delete();
        if (PRE != 0) push_all(INIT);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Push one token upstream once req_l allows it; a timeout counts as a failure.
    task automatic write_tok(input int unsigned v);
        int waited;
        waited = 0;
        while (!bus.req_l && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus.req_l) begin
            n_cmp++;
            n_err++;
            $display("FAIL write_timeout: got req_l=0 for 200 cycles, expected req_l=1");
        end else begin
            bus.ack_l = 1'b1;
            bus.din   = DW'(v);
            push_all(v);
            n_sent++;
            @(posedge clk);
            #1;
            bus.ack_l = 1'b0;
        end
    endtask

    // Drain with all consumers enabled, bounded.
    task automatic drain(input int budget);
        int waited;
        waited = 0;
        bus.req_r = '1;
        while (bus.count != 0 && waited < budget) begin
            @(posedge clk);
            #1;
            waited++;
        end
        cycles(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_sent = 0;
        stress_done = 1'b0;
        for (int k = 0; k < NOUT; k++) n_rcv[k] = 0;
        rst       = 1'b0;
        bus.ack_l = 1'b0;
        bus.din   = '0;
        bus.req_r = '0;

        // Reset state, no clock edge yet.
        #1;
        check("rst_req_l", 64'(bus.req_l), 64'd0);
        check("rst_ack_r", 64'(bus.ack_r), 64'd0);
        check("rst_dout",  64'(bus.dout),  64'd0);
        check("rst_count", 64'(bus.count), 64'(PRE));
        clear_expect();
        cycles(2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_req_l", 64'(bus.req_l), 64'd1);

        // Fill with every consumer stalled.
        for (int i = 0; i < DEPTH - PRE; i++) write_tok(i);
        check("full_count", 64'(bus.count), 64'(DEPTH));
        check("full_req_l", 64'(bus.req_l), 64'd0);
        bus.ack_l = 1'b1;
        bus.din   = 32'd99;
        cycles(1);
        bus.ack_l = 1'b0;
        check("drop_count", 64'(bus.count), 64'(DEPTH));

        // Skew: consumer 0 drains alone, then 1, then 2 frees the buffer.
        bus.req_r = 3'b001;
        cycles(12);
        check("skew0_count", 64'(bus.count), 64'(DEPTH));
        check("skew0_req_l", 64'(bus.req_l), 64'd0);
        check("skew0_rcv",   64'(n_rcv[0]),  64'(DEPTH));
        bus.req_r = 3'b011;
        cycles(12);
        check("skew1_count", 64'(bus.count), 64'(DEPTH));
        check("skew1_req_l", 64'(bus.req_l), 64'd0);
        bus.req_r = 3'b111;
        cycles(1);
        check("slow_read_req_l", 64'(bus.req_l), 64'd1);
        check("slow_read_count", 64'(bus.count), 64'(DEPTH - 1));
        cycles(12);
        check("drained_count", 64'(bus.count), 64'd0);

        // Latency: write 7 into an empty buffer with all consumers requesting.
        bus.ack_l = 1'b1;
        bus.din   = 32'd7;
        push_all(7);
        n_sent++;
        cycles(1);
        bus.ack_l = 1'b0;
        check("lat_edge_n_ack",   64'(bus.ack_r), 64'd0);
        check("lat_edge_n_count", 64'(bus.count), 64'd1);
        cycles(1);
        check("lat_edge_n1_ack",   64'(bus.ack_r), 64'(3'b111));
        check("lat_edge_n1_count", 64'(bus.count), 64'd0);
        cycles(3);

        // Mid-operation reset drops in-flight tokens, asynchronously.
        bus.req_r = '0;
        write_tok(40);
        write_tok(41);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_req_l", 64'(bus.req_l), 64'd0);
        check("mid_rst_count", 64'(bus.count), 64'(PRE));
        check("mid_rst_dout",  64'(bus.dout),  64'd0);
        clear_expect();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_req_l", 64'(bus.req_l), 64'd1);
        for (int k = 0; k < NOUT; k++) n_rcv[k] = 0;
        n_sent = PRE;

        // Stress: random per-consumer stalls against a steady producer.
        fork
            begin
                for (int i = 0; i < N_STRESS; i++) write_tok(i);
                stress_done = 1'b1;
            end
            begin
                while (!stress_done) begin
                    for (int k = 0; k < NOUT; k++) bus.req_r[k] = ($urandom_range(0, 9) >= 3);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain(400);
        check("end_count", 64'(bus.count), 64'd0);
        for (int k = 0; k < NOUT; k++) begin
            check($sformatf("end_queue[%0d]", k), 64'(exp_q[k].size()), 64'd0);
            check($sformatf("end_rcv[%0d]", k),   64'(n_rcv[k]),        64'(n_sent));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
